// File: rtl/depen_gen.sv
// Operand dependency and load-use hazard detector for a 5-stage pipeline.
// A shadow copy of the EXE/MEM/WB destinations selects forward sources and raises a one-cycle stall.
module depen_gen (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic        use_a_id,
    input  logic        use_b_id,
    input  logic        store_id,
    input  logic [4:0]  wn_id,
    input  logic        wreg_id,
    input  logic        m2reg_id,
    input  logic        flush,
    output logic [1:0]  ADEPEN_id,
    output logic [1:0]  BDEPEN_id,
    output logic [1:0]  STOREDEPEN_id,
    output logic        stall,
    output logic [15:0] stall_cnt
);

    typedef struct packed {
        logic [4:0] wn;
        logic       wreg;
        logic       m2reg;
    } entry_t;

    entry_t      exe_d, exe_q;
    entry_t      mem_d, mem_q;
    entry_t      wb_d,  wb_q;
    logic [15:0] stall_cnt_d, stall_cnt_q;
    logic        load_use;

    // $0 is hardwired, so a write to it never produces a forwardable value.
    function automatic logic hit(input entry_t e, input logic [4:0] r);
        return e.wreg && (e.wn == r) && (r != 5'd0);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic use_r, input logic [4:0] r,
                                           input entry_t ex, input entry_t me, input entry_t wb);
        logic [1:0] sel;
        sel = 2'b00;
        if (use_r) begin
            if (hit(ex, r))      sel = 2'b01;
            else if (hit(me, r)) sel = 2'b10;
            else if (hit(wb, r)) sel = 2'b11;
        end
        return sel;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        ADEPEN_id     = 2'b00;
        BDEPEN_id     = 2'b00;
        STOREDEPEN_id = 2'b00;

        // Store data is consumed in MEM, so a load in EXE only hurts ALU operands.
        load_use = exe_q.m2reg &&
                   ((use_a_id && hit(exe_q, rs_id)) || (use_b_id && hit(exe_q, rt_id)));
        stall    = !flush && load_use;

        if (!stall) begin
            ADEPEN_id     = fwd_sel(use_a_id, rs_id, exe_q, mem_q, wb_q);
            BDEPEN_id     = fwd_sel(use_b_id, rt_id, exe_q, mem_q, wb_q);
            STOREDEPEN_id = fwd_sel(store_id, rt_id, exe_q, mem_q, wb_q);
        end

        exe_d = '0;
        if (!stall && !flush) begin
            exe_d.wn    = wn_id;
            exe_d.wreg  = wreg_id;
            exe_d.m2reg = m2reg_id;
        end
        mem_d = exe_q;
        wb_d  = mem_q;

        stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
        stall_cnt   = stall_cnt_q;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            exe_q       <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            exe_q       <= exe_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_depen_gen.sv
// Directed table-driven bench for depen_gen: forwarding priority, load-use stall,
// flush bubbles, stall counter saturation and asynchronous reset.
module tb_depen_gen;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic [4:0]  rs_id, rt_id, wn_id;
    logic        use_a_id, use_b_id, store_id, wreg_id, m2reg_id, flush;
    logic [1:0]  ADEPEN_id, BDEPEN_id, STOREDEPEN_id;
    logic        stall;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    depen_gen dut (
        .Clock(Clock), .Resetn(Resetn),
        .rs_id(rs_id), .rt_id(rt_id), .use_a_id(use_a_id), .use_b_id(use_b_id),
        .store_id(store_id), .wn_id(wn_id), .wreg_id(wreg_id), .m2reg_id(m2reg_id),
        .flush(flush), .ADEPEN_id(ADEPEN_id), .BDEPEN_id(BDEPEN_id),
        .STOREDEPEN_id(STOREDEPEN_id), .stall(stall), .stall_cnt(stall_cnt)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [4:0]  rs, rt;
        logic        ua, ub, st;
        logic [4:0]  wn;
        logic        wreg, m2, fl;
        logic [1:0]  ea, eb, es;
        logic        estall;
        logic [15:0] ecnt;
    } vec_t;

    function automatic vec_t mk(int rs, int rt, bit ua, bit ub, bit st, int wn, bit wreg, bit m2,
                                bit fl, int ea, int eb, int es, bit estall, int ecnt);
        vec_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.ua = ua; v.ub = ub; v.st = st;
        v.wn = 5'(wn); v.wreg = wreg; v.m2 = m2; v.fl = fl;
        v.ea = 2'(ea); v.eb = 2'(eb); v.es = 2'(es); v.estall = estall; v.ecnt = 16'(ecnt);
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        rs_id = v.rs; rt_id = v.rt; use_a_id = v.ua; use_b_id = v.ub; store_id = v.st;
        wn_id = v.wn; wreg_id = v.wreg; m2reg_id = v.m2; flush = v.fl;
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        check({tag, ".A"},     16'(ADEPEN_id),     16'(v.ea));
        check({tag, ".B"},     16'(BDEPEN_id),     16'(v.eb));
        check({tag, ".S"},     16'(STOREDEPEN_id), 16'(v.es));
        check({tag, ".stall"}, 16'(stall),         16'(v.estall));
        check({tag, ".cnt"},   stall_cnt,          v.ecnt);
    endtask

    // Drive after the falling edge, check 1 time unit later, state advances at the next rising edge.
    task automatic apply(input string tag, input vec_t v);
        @(negedge Clock);
        drive(v);
        #1;
        check_outs(tag, v);
    endtask

    vec_t tbl[20];
    vec_t lw7, use7, nop;

    initial begin
        //            rs rt ua ub st wn wr m2 fl  eA eB eS stl cnt
        tbl[0]  = mk( 1, 2, 1, 1, 0, 3, 1, 0, 0,  0, 0, 0, 0, 0);  // add $3
        tbl[1]  = mk( 3, 4, 1, 1, 0, 8, 1, 0, 0,  1, 0, 0, 0, 0);  // sub uses $3 from EXE
        tbl[2]  = mk( 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[3]  = mk( 0, 0, 1, 1, 0, 5, 1, 0, 0,  0, 0, 0, 0, 0);  // add $5
        tbl[4]  = mk( 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[5]  = mk( 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[6]  = mk( 5, 5, 1, 1, 1, 5, 1, 0, 0,  3, 3, 3, 0, 0);  // $5 in WB, rewrites $5
        tbl[7]  = mk( 5, 5, 1, 1, 0, 5, 1, 0, 0,  1, 1, 0, 0, 0);  // younger write wins
        tbl[8]  = mk( 5, 5, 1, 1, 1, 0, 0, 0, 0,  1, 1, 1, 0, 0);  // EXE over MEM
        tbl[9]  = mk( 5, 5, 1, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0);  // MEM over WB
        tbl[10] = mk( 1, 0, 1, 0, 0, 7, 1, 1, 0,  0, 0, 0, 0, 0);  // lw $7
        tbl[11] = mk( 7, 2, 1, 1, 0, 9, 1, 0, 0,  0, 0, 0, 1, 0);  // load-use stall
        tbl[12] = mk( 7, 2, 1, 1, 0, 9, 1, 0, 0,  2, 0, 0, 0, 1);  // replay, load in MEM
        tbl[13] = mk( 0, 0, 1, 0, 0, 7, 1, 1, 0,  0, 0, 0, 0, 1);  // lw $7
        tbl[14] = mk( 9, 7, 1, 0, 1, 0, 0, 0, 0,  2, 0, 1, 0, 1);  // sw: store data only, no stall
        tbl[15] = mk( 9, 0, 1, 0, 0, 0, 1, 0, 0,  3, 0, 0, 0, 1);  // write $0
        tbl[16] = mk( 0, 7, 1, 1, 0, 6, 1, 1, 0,  0, 3, 0, 0, 1);  // read $0 never forwards; lw $6
        tbl[17] = mk( 6, 0, 1, 0, 0,10, 1, 0, 1,  1, 0, 0, 0, 1);  // load-use with flush
        tbl[18] = mk(10, 6, 1, 1, 0, 0, 0, 0, 0,  0, 2, 0, 0, 1);  // flushed $10 never entered
        tbl[19] = mk( 6, 6, 0, 0, 1, 0, 0, 0, 0,  0, 0, 3, 0, 1);  // use flags gate A/B

        lw7  = mk(0, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0);
        use7 = mk(7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        nop  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state, with ID inputs that would otherwise look like dependencies
        Resetn = 1'b0;
        drive(mk(7, 7, 1, 1, 1, 7, 1, 1, 0, 0, 0, 0, 0, 0));
        #2;
        check_outs("reset", nop);
        @(negedge Clock);
        @(negedge Clock);
        Resetn = 1'b1;

        for (int i = 0; i < 20; i++)
            apply($sformatf("vec%0d", i), tbl[i]);

        // Saturation: preload the counter near its ceiling, then stall three times
        @(negedge Clock);
        drive(nop);
        force dut.stall_cnt_q = 16'hFFFD;
        #1;
        release dut.stall_cnt_q;
        #1;
        lw7.ecnt = 16'hFFFD;  apply("sat_lw0", lw7);
        use7.ecnt = 16'hFFFD; apply("sat_st0", use7);
        lw7.ecnt = 16'hFFFE;  apply("sat_lw1", lw7);
        use7.ecnt = 16'hFFFE; apply("sat_st1", use7);
        lw7.ecnt = 16'hFFFF;  apply("sat_lw2", lw7);
        use7.ecnt = 16'hFFFF; apply("sat_st2", use7);
        lw7.ecnt = 16'hFFFF;  apply("sat_hold", lw7);
        use7.ecnt = 16'hFFFF; apply("mid_stall", use7);

        // Asynchronous reset in the middle of a stall cycle
        #1;
        Resetn = 1'b0;
        #1;
        use7.ea = 2'b00; use7.estall = 1'b0; use7.ecnt = 16'h0000;
        check_outs("rst_async", use7);
        @(negedge Clock);
        Resetn = 1'b1;
        apply("post_rst", mk(7, 7, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
